// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: load/store mode codes, arbiter state encoding and request
// record shared by the data-memory arbiter slice.  Rev 1.0
`default_nettype none

package dmem_arbiter_pkg;

   localparam int unsigned DM_MODE_W = 3;

   localparam logic [DM_MODE_W-1:0] DM_B  = 3'b000;
   localparam logic [DM_MODE_W-1:0] DM_H  = 3'b001;
   localparam logic [DM_MODE_W-1:0] DM_W  = 3'b010;
   localparam logic [DM_MODE_W-1:0] DM_BU = 3'b100;
   localparam logic [DM_MODE_W-1:0] DM_HU = 3'b101;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_ACCESS = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic [31:0]          addr;
      logic [31:0]          wdata;
      logic                 we;
      logic [DM_MODE_W-1:0] mode;
   } dmem_req_t;

   // Watchdog counter width: just wide enough to reach TIMEOUT-1.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one req/ready data-memory channel (requester or memory side).
// Rev 1.0
`default_nettype none

interface dmem_arbiter_if;
   import dmem_arbiter_pkg::*;

   logic                 req;
   logic [31:0]          addr;
   logic [31:0]          wdata;
   logic                 we;
   logic [DM_MODE_W-1:0] mode;
   logic [31:0]          rdata;
   logic                 ready;
   logic                 err;

   modport master (
      output req, addr, wdata, we, mode,
      input  rdata, ready, err
   );

   modport slave (
      input  req, addr, wdata, we, mode,
      output rdata, ready, err
   );

   // The memory never reports an error, so its channel carries no err.
   modport mem_master (
      output req, addr, wdata, we, mode,
      input  rdata, ready
   );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_pick.sv
// dmem_arb_pick: combinational two-way winner selection, round-robin or fixed
// priority to port 0.  Rev 1.0
`default_nettype none

module dmem_arb_pick #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_grant_i,
   output logic valid_o,
   output logic winner_o
);

   assign valid_o = req0_i | req1_i;

   always_comb begin
      winner_o = req1_i;
      if (req0_i && req1_i) begin
         winner_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_i;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data memory between the LSU (port 0)
// and a debug/DMA master (port 1), with an ACCESS watchdog.  Rev 1.0
`default_nettype none

module dmem_arbiter #(
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic               clk,
   input  logic               rst,
   dmem_arbiter_if.slave      p0,
   dmem_arbiter_if.slave      p1,
   dmem_arbiter_if.mem_master mem,
   output logic               busy,
   output logic               grant
);
   import dmem_arbiter_pkg::*;

   localparam int unsigned      CNT_W     = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
   localparam logic             WDOG_EN   = (TIMEOUT != 0);

   arb_state_e       state_q;
   dmem_req_t        req_q;
   logic [CNT_W-1:0] cnt_q;
   logic             grant_q;
   logic             last_grant_q;
   logic             busy_q;

   logic             pick_valid;
   logic             pick_winner;
   dmem_req_t        pick_req;
   logic             timeout_hit;
   logic             xfer_done;

   dmem_arb_pick #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_pick (
      .req0_i       (p0.req),
      .req1_i       (p1.req),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid),
      .winner_o     (pick_winner)
   );

   always_comb begin
      pick_req = '0;
      if (pick_winner) begin
         pick_req.addr  = p1.addr;
         pick_req.wdata = p1.wdata;
         pick_req.we    = p1.we;
         pick_req.mode  = p1.mode;
      end else begin
         pick_req.addr  = p0.addr;
         pick_req.wdata = p0.wdata;
         pick_req.we    = p0.we;
         pick_req.mode  = p0.mode;
      end
   end

   // A completion in the limit cycle beats the watchdog.
   always_comb begin
      timeout_hit = WDOG_EN && (state_q == ARB_ACCESS) && (cnt_q == CNT_LIMIT) && !mem.ready;
      xfer_done   = (state_q == ARB_ACCESS) && (mem.ready || timeout_hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         req_q        <= '0;
         cnt_q        <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_valid) begin
                  req_q        <= pick_req;
                  grant_q      <= pick_winner;
                  last_grant_q <= pick_winner;
                  cnt_q        <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               if (xfer_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ARB_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   // mem_req drops in the ready cycle so the memory sees no second access.
   assign mem.req   = (state_q == ARB_ACCESS) && !mem.ready && !timeout_hit;
   assign mem.addr  = req_q.addr;
   assign mem.wdata = req_q.wdata;
   assign mem.we    = req_q.we;
   assign mem.mode  = req_q.mode;

   assign p0.ready = xfer_done && !grant_q;
   assign p0.err   = xfer_done && !grant_q && timeout_hit;
   assign p0.rdata = (xfer_done && !grant_q && mem.ready) ? mem.rdata : 32'h0;

   assign p1.ready = xfer_done && grant_q;
   assign p1.err   = xfer_done && grant_q && timeout_hit;
   assign p1.rdata = (xfer_done && grant_q && mem.ready) ? mem.rdata : 32'h0;

   assign busy  = busy_q;
   assign grant = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against small memory models.
// Rev 1.0
`default_nettype none

module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic clk;
   logic rst;
   logic a_busy, a_grant, b_busy, b_grant;

   dmem_arbiter_if a_p0 ();
   dmem_arbiter_if a_p1 ();
   dmem_arbiter_if a_mem ();
   dmem_arbiter_if b_p0 ();
   dmem_arbiter_if b_p1 ();
   dmem_arbiter_if b_mem ();

   dmem_arbiter #(.TIMEOUT(8), .FIXED_PRIO(0)) dut_a (
      .clk (clk), .rst (rst), .p0 (a_p0), .p1 (a_p1), .mem (a_mem),
      .busy (a_busy), .grant (a_grant)
   );

   dmem_arbiter #(.TIMEOUT(16), .FIXED_PRIO(1)) dut_b (
      .clk (clk), .rst (rst), .p0 (b_p0), .p1 (b_p1), .mem (b_mem),
      .busy (b_busy), .grant (b_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign a_mem.err = 1'b0;
   assign b_mem.err = 1'b0;

   // Memory A: word array, programmable latency, optional never-ready mode.
   logic [31:0] mem_a [0:255];
   int          lat_a = 1;
   bit          hang_a = 1'b0;
   bit          init_a = 1'b0;
   bit          pend_a = 1'b0;
   int          k_a = 0;
   int          nrd_a = 0;
   int          nwr_a = 0;
   logic        fire_a;

   function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] lane, input logic [2:0] mode);
      logic [31:0] r;
      r = old;
      case (mode)
         DM_B:    r[lane*8 +: 8] = wd[7:0];
         DM_H:    r[lane[1]*16 +: 16] = wd[15:0];
         default: r = wd;
      endcase
      return r;
   endfunction

   always_comb begin
      fire_a = 1'b0;
      if (!rst) begin
         if (pend_a) fire_a = (k_a + 1 >= lat_a);
         else        fire_a = a_mem.req && !hang_a && (lat_a <= 1);
      end
   end

   always @(posedge clk) begin
      a_mem.ready <= 1'b0;
      a_mem.rdata <= 32'h0;
      if (rst) begin
         pend_a <= 1'b0;
         if (!init_a) begin
            mem_a[64] <= 32'h1234_5678;
            mem_a[65] <= 32'hCAFE_F00D;
            init_a    <= 1'b1;
         end
      end else if (pend_a) begin
         if (fire_a) pend_a <= 1'b0;
         else        k_a <= k_a + 1;
      end else if (a_mem.req && !hang_a && lat_a > 1) begin
         pend_a <= 1'b1;
         k_a    <= 1;
      end
      if (fire_a) begin
         a_mem.ready <= 1'b1;
         if (a_mem.we) begin
            mem_a[a_mem.addr[9:2]] <= st_merge(mem_a[a_mem.addr[9:2]], a_mem.wdata,
                                               a_mem.addr[1:0], a_mem.mode);
            nwr_a <= nwr_a + 1;
         end else begin
            a_mem.rdata <= mem_a[a_mem.addr[9:2]];
            nrd_a       <= nrd_a + 1;
         end
      end
   end

   // Memory B: fixed latency 1, read data unused.
   always @(posedge clk) begin
      b_mem.ready <= !rst && b_mem.req;
      b_mem.rdata <= 32'h0;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_a(input int port, input int budget, output int cyc,
                         output logic [31:0] rd, output logic er);
      cyc = 0;
      rd  = 32'h0;
      er  = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (a_p0.ready || a_p1.ready) begin
            cyc = i;
            chk("ready_to_requester", (port == 0) ? a_p0.ready : a_p1.ready, 1);
            chk("no_ready_to_other", (port == 0) ? a_p1.ready : a_p0.ready, 0);
            rd = (port == 0) ? a_p0.rdata : a_p1.rdata;
            er = (port == 0) ? a_p0.err : a_p1.err;
            return;
         end
      end
      n_total++;
      $error("FAIL ready_wait_expired: observed no ready after %0d cycles, expected one", budget);
   endtask

   int          cyc, rd_before, wr_before, n0, n1, owner, found;
   logic [31:0] rd;
   logic        er, seen;

   initial begin
      rst = 1'b1;
      {a_p0.req, a_p0.addr, a_p0.wdata, a_p0.we, a_p0.mode} = '0;
      {a_p1.req, a_p1.addr, a_p1.wdata, a_p1.we, a_p1.mode} = '0;
      {b_p0.req, b_p0.addr, b_p0.wdata, b_p0.we, b_p0.mode} = '0;
      {b_p1.req, b_p1.addr, b_p1.wdata, b_p1.we, b_p1.mode} = '0;
      repeat (3) step();

      chk("rst_mem_req", a_mem.req, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_grant", a_grant, 0);
      chk("rst_p0_ready", a_p0.ready, 0);
      chk("rst_p1_ready", a_p1.ready, 0);
      chk("rst_mem_addr", a_mem.addr, 0);
      chk("rst_b_busy", b_busy, 0);
      rst = 1'b0;
      step();

      // 1: single LW, latency 1
      a_p0.req = 1'b1; a_p0.addr = 32'h100; a_p0.we = 1'b0; a_p0.mode = DM_W;
      chk("t1_c0_mem_req", a_mem.req, 0);
      step();
      chk("t1_c1_mem_req", a_mem.req, 1);
      chk("t1_c1_busy", a_busy, 1);
      chk("t1_c1_grant", a_grant, 0);
      chk("t1_c1_p0_ready", a_p0.ready, 0);
      chk("t1_c1_mem_addr", a_mem.addr, 32'h100);
      step();
      chk("t1_c2_mem_req", a_mem.req, 0);
      chk("t1_c2_p0_ready", a_p0.ready, 1);
      chk("t1_c2_p0_rdata", a_p0.rdata, 32'h1234_5678);
      chk("t1_c2_p0_err", a_p0.err, 0);
      chk("t1_c2_p1_ready", a_p1.ready, 0);
      chk("t1_c2_p1_rdata", a_p1.rdata, 0);
      a_p0.req = 1'b0;
      step();
      chk("t1_c3_busy", a_busy, 0);
      chk("t1_c3_p0_ready", a_p0.ready, 0);
      chk("t1_c3_p0_rdata", a_p0.rdata, 0);

      // 2: p1 SB then p0 LW sees the merged byte
      rd_before = nrd_a; wr_before = nwr_a;
      a_p1.req = 1'b1; a_p1.addr = 32'h103; a_p1.wdata = 32'hAB; a_p1.we = 1'b1; a_p1.mode = DM_B;
      wait_a(1, 10, cyc, rd, er);
      chk("t2_sb_latency", cyc, 2);
      chk("t2_sb_err", er, 0);
      a_p1.req = 1'b0;
      step();
      a_p0.req = 1'b1; a_p0.addr = 32'h100; a_p0.we = 1'b0; a_p0.mode = DM_W;
      wait_a(0, 10, cyc, rd, er);
      chk("t2_lw_rdata", rd, 32'hAB34_5678);
      a_p0.req = 1'b0;
      step();
      chk("t2_write_count", nwr_a - wr_before, 1);
      chk("t2_read_count", nrd_a - rd_before, 1);

      // 3: round-robin under continuous contention
      rst = 1'b1;
      step();
      rst = 1'b0;
      a_p0.req = 1'b1; a_p0.addr = 32'h100; a_p0.we = 1'b0; a_p0.mode = DM_W;
      a_p1.req = 1'b1; a_p1.addr = 32'h104; a_p1.we = 1'b0; a_p1.mode = DM_W;
      for (int t = 0; t < 4; t++) begin
         owner = t % 2;
         found = 0;
         for (int i = 0; i < 6 && found == 0; i++) begin
            step();
            if (a_p0.ready || a_p1.ready) found = 1;
         end
         if (found == 0) begin
            n_total++;
            $error("FAIL t3_no_ready: observed none in transaction %0d, expected a ready", t);
         end else begin
            chk("t3_grant", a_grant, owner);
            chk("t3_p0_ready", a_p0.ready, (owner == 0));
            chk("t3_p1_ready", a_p1.ready, (owner == 1));
            chk("t3_rdata", (owner == 1) ? a_p1.rdata : a_p0.rdata,
                (owner == 1) ? 32'hCAFE_F00D : 32'hAB34_5678);
         end
      end
      a_p0.req = 1'b0;
      a_p1.req = 1'b0;
      step();

      // 4: fixed priority, port 1 starves
      b_p0.req = 1'b1; b_p0.mode = DM_W;
      b_p1.req = 1'b1; b_p1.mode = DM_W;
      n0 = 0; n1 = 0;
      for (int i = 0; i < 20 && n0 < 4; i++) begin
         step();
         if (b_p1.ready) n1++;
         if (b_p0.ready) begin
            chk("t4_grant", b_grant, 0);
            n0++;
         end
      end
      chk("t4_p0_count", n0, 4);
      chk("t4_p1_count", n1, 0);
      b_p0.req = 1'b0;
      b_p1.req = 1'b0;
      step();

      // 5: watchdog abort, TIMEOUT=8
      hang_a = 1'b1;
      wr_before = nwr_a;
      a_p0.req = 1'b1; a_p0.addr = 32'h200; a_p0.wdata = 32'hDEAD_BEEF; a_p0.we = 1'b1; a_p0.mode = DM_W;
      seen = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         step();
         seen = seen | a_p0.ready;
         if (c == 7) chk("t5_c7_mem_req", a_mem.req, 1);
      end
      chk("t5_early_ready", seen, 0);
      step();
      chk("t5_c8_p0_ready", a_p0.ready, 1);
      chk("t5_c8_p0_err", a_p0.err, 1);
      chk("t5_c8_mem_req", a_mem.req, 0);
      chk("t5_c8_p0_rdata", a_p0.rdata, 0);
      chk("t5_c8_busy", a_busy, 1);
      a_p0.req = 1'b0;
      step();
      chk("t5_c9_busy", a_busy, 0);
      chk("t5_c9_p0_ready", a_p0.ready, 0);
      chk("t5_no_write", nwr_a - wr_before, 0);
      hang_a = 1'b0;

      // 6: reset mid-transaction, then a clean p1 read at latency 4
      lat_a = 4;
      a_p0.req = 1'b1; a_p0.addr = 32'h100; a_p0.we = 1'b0; a_p0.mode = DM_W;
      step();
      chk("t6_c1_mem_req", a_mem.req, 1);
      step();
      rst = 1'b1;
      step();
      chk("t6_c3_mem_req", a_mem.req, 0);
      chk("t6_c3_busy", a_busy, 0);
      chk("t6_c3_p0_ready", a_p0.ready, 0);
      rst = 1'b0;
      a_p0.req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         seen = seen | a_p0.ready;
      end
      chk("t6_no_stray_ready", seen, 0);
      a_p1.req = 1'b1; a_p1.addr = 32'h104; a_p1.we = 1'b0; a_p1.mode = DM_W;
      wait_a(1, 12, cyc, rd, er);
      chk("t6_p1_latency", cyc, 5);
      chk("t6_p1_rdata", rd, 32'hCAFE_F00D);
      chk("t6_p1_err", er, 0);
      a_p1.req = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no finish by 100000, expected earlier end");
      $fatal(1, "simulation time limit reached");
   end

endmodule

`default_nettype wire
